fb_pixel_sink: RTL and testbench
================================

// Module: fb_pixel_sink
// PURPOSE
//  Receiving end of the pixel stream (x_stream/y_stream/color_stream/writeEn) produced by the
//  rectangle/shape renderers. Clips each pixel to the 320x240 screen, buffers it in a small FIFO
//  and writes it into the shared single-port framebuffer RAM in cycles granted by the scan-out
//  arbiter. Also provides a full-screen clear.
// PARAMETERS
//  SCREEN_W    320  visible width in pixels
//  SCREEN_H    240  visible height in pixels
//  FIFO_DEPTH  8    pixel FIFO entries; power of two, >= 2
//  ADDR_W      17   framebuffer address width; must hold SCREEN_W*SCREEN_H-1 (76799)
// PORTS
//  clk           in   1       system clock (50 MHz)
//  resetn        in   1       synchronous active-low reset
//  x_stream      in   9       pixel x coordinate
//  y_stream      in   8       pixel y coordinate
//  color_stream  in   3       pixel colour
//  writeEn       in   1       pixel valid; one pixel per high cycle
//  ready         out  1       1 = pixel on writeEn is accepted this cycle
//  clear_req     in   1       pulse: request full-screen clear
//  clear_color   in   3       colour for clear, sampled in the cycle clear_req is taken
//  clear_done    out  1       one-cycle pulse after the last clear write
//  busy          out  1       1 = FIFO non-empty, clear pending, or clear in progress
//  mem_grant     in   1       1 = framebuffer port free for this sink this cycle
//  mem_we        out  1       framebuffer write strobe
//  mem_addr      out  ADDR_W  framebuffer address
//  mem_data      out  3       framebuffer write data
//  drop_count    out  16      saturating count of discarded pixels
// BEHAVIOUR
//  Reset (resetn=0 at posedge): FIFO emptied, state IDLE, clear_pending=0, drop_count=0.
//   Outputs: clear_done=0, busy=0, mem_we=0, mem_addr=0, mem_data=0. ready=1 in the first cycle after reset.
//   A reset mid-clear or mid-drain abandons the operation. No clear_done is produced.
//  ready = (state != CLEAR) && !clear_pending && (fifo_count < FIFO_DEPTH).
//   ready is based on the count at the start of the cycle, so a full FIFO does not accept a pixel
//   even when it pops in the same cycle.
//  Accept: writeEn && ready && x<SCREEN_W && y<SCREEN_H -> push {addr, colour} into the FIFO.
//   addr = y*SCREEN_W + x, computed at full ADDR_W width. For 320: (y<<8)+(y<<6)+x.
//  Drop: writeEn && (!ready || x>=SCREEN_W || y>=SCREEN_H) -> no push; drop_count+1, saturating at 0xFFFF.
//  States:
//   IDLE:  FIFO serviced. A clear_req sets clear_pending and latches clear_color.
//          Go to CLEAR when clear_pending && FIFO empty.
//   CLEAR: clr_addr starts at 0. Go back to IDLE after the write at SCREEN_W*SCREEN_H-1 is granted.
//          clear_done=1 in the cycle after that write. clear_pending cleared on entry.
//          clear_req in CLEAR, or while already pending, is ignored.
//  Memory port (combinational from registered state, one write per granted cycle):
//   IDLE:  mem_we = mem_grant && !fifo_empty; mem_addr/mem_data = FIFO head. Pop when mem_we=1.
//   CLEAR: mem_we = mem_grant; mem_addr = clr_addr; mem_data = latched colour.
//          clr_addr increments only on a granted cycle.
//   When mem_we=0, mem_addr/mem_data hold their last driven values.
//  Latency: a pixel accepted at edge N can appear on mem_we at cycle N+1 at the earliest.
//   Throughput is 1 pixel/cycle while mem_grant=1.
//  Push and pop in the same cycle: fifo_count unchanged; FIFO order preserved.
//   Pointers wrap modulo FIFO_DEPTH.
//  busy = !fifo_empty || clear_pending || state==CLEAR.
// TESTING
//  1. Reset, then x=5,y=2,c=3 with writeEn, grant=1 -> next cycle mem_we=1, addr=645, data=3;
//     busy=0 after that.
//  2. grant=0, 9 consecutive in-bounds pixels -> ready falls after 8 are accepted; 9th dropped
//     (drop_count=1). grant=1 -> 8 writes in order.
//  3. Pixels (320,0) and (0,240) -> no mem_we; drop_count=2. Pixel (319,239) -> addr=76799.
//  4. clear_req with 3 pixels queued, clear_color=5, grant=1 -> 3 pixel writes, then 76800 writes
//     addr 0..76799 data 5; clear_done pulses once; ready=0 throughout.
//  5. Clear with grant toggling 1/0 every cycle -> addresses are never skipped or repeated;
//     clear_done only after addr 76799.
//  6. resetn=0 at clr_addr=1000 -> all outputs at reset values next cycle; no clear_done;
//     drop_count=0; ready=1.

Source files
------------

// File: rtl/fb_pixel_sink_if.sv
// Pixel stream from the shape renderers into the framebuffer sink.
// The renderer drives coordinates, colour and valid; the sink returns ready.
interface fb_pixel_sink_if;
  logic [8:0] x_stream;
  logic [7:0] y_stream;
  logic [2:0] color_stream;
  logic       writeEn;
  logic       ready;

  modport master (output x_stream, y_stream, color_stream, writeEn, input ready);
  modport slave  (input x_stream, y_stream, color_stream, writeEn, output ready);
endinterface

// File: rtl/fb_pixel_sink.sv
// Clips renderer pixels to the screen, buffers them in a small FIFO and writes them
// to the shared framebuffer in granted cycles; also performs a full-screen clear.
module fb_pixel_sink #(
  parameter int unsigned SCREEN_W   = 320,
  parameter int unsigned SCREEN_H   = 240,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              resetn,
  fb_pixel_sink_if.slave    pix,
  input  logic              clear_req,
  input  logic [2:0]        clear_color,
  output logic              clear_done,
  output logic              busy,
  input  logic              mem_grant,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic [15:0]       drop_count
);
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned LAST_ADDR = SCREEN_W * SCREEN_H - 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        color;
  } pix_entry_t;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e            state_q, state_d;
  pix_entry_t        fifo_q [FIFO_DEPTH];
  pix_entry_t        fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              clear_pending_q, clear_pending_d;
  logic [2:0]        clear_color_q, clear_color_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clear_done_q, clear_done_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [2:0]        last_data_q, last_data_d;

  logic              fifo_empty, in_bounds, ready_c, push, pop;
  logic [ADDR_W-1:0] src_addr;
  logic [2:0]        src_data;
  pix_entry_t        head, new_entry;

  // Acceptance is judged on start-of-cycle occupancy, so a full FIFO never takes a pixel.
  always_comb begin
    fifo_empty      = (count_q == '0);
    in_bounds       = (32'(pix.x_stream) < SCREEN_W) && (32'(pix.y_stream) < SCREEN_H);
    ready_c         = (state_q != ST_CLEAR) && !clear_pending_q &&
                      (count_q < CNT_W'(FIFO_DEPTH));
    head            = fifo_q[rd_ptr_q];
    new_entry.addr  = ADDR_W'(pix.y_stream) * ADDR_W'(SCREEN_W) + ADDR_W'(pix.x_stream);
    new_entry.color = pix.color_stream;
  end

  assign pix.ready = ready_c;

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    clear_color_d   = clear_color_q;
    clr_addr_d      = clr_addr_q;
    clear_done_d    = 1'b0;
    mem_we          = 1'b0;
    src_addr        = head.addr;
    src_data        = head.color;

    case (state_q)
      ST_IDLE: begin
        mem_we = mem_grant && !fifo_empty;
        if (clear_pending_q && fifo_empty) begin
          state_d         = ST_CLEAR;
          clear_pending_d = 1'b0;
          clr_addr_d      = '0;
        end else if (clear_req && !clear_pending_q) begin
          clear_pending_d = 1'b1;
          clear_color_d   = clear_color;
        end
      end
      ST_CLEAR: begin
        mem_we   = mem_grant;
        src_addr = clr_addr_q;
        src_data = clear_color_q;
        if (mem_grant) begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
          if (clr_addr_q == ADDR_W'(LAST_ADDR)) begin
            state_d      = ST_IDLE;
            clear_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Memory outputs hold their last driven value on idle cycles.
    mem_addr    = mem_we ? src_addr : last_addr_q;
    mem_data    = mem_we ? src_data : last_data_q;
    last_addr_d = mem_addr;
    last_data_d = mem_data;
  end

  always_comb begin
    push         = pix.writeEn && ready_c && in_bounds;
    pop          = mem_we && (state_q == ST_IDLE);
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_count_d = drop_count_q;

    if (push) begin
      fifo_d[wr_ptr_q] = new_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (pix.writeEn && !push && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      fifo_q          <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      clear_pending_q <= 1'b0;
      clear_color_q   <= '0;
      clr_addr_q      <= '0;
      clear_done_q    <= 1'b0;
      drop_count_q    <= '0;
      last_addr_q     <= '0;
      last_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      clear_pending_q <= clear_pending_d;
      clear_color_q   <= clear_color_d;
      clr_addr_q      <= clr_addr_d;
      clear_done_q    <= clear_done_d;
      drop_count_q    <= drop_count_d;
      last_addr_q     <= last_addr_d;
      last_data_q     <= last_data_d;
    end
  end

  assign clear_done = clear_done_q;
  assign drop_count = drop_count_q;
  assign busy       = !fifo_empty || clear_pending_q || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Drives a full-size sink and a tiny-screen sink with the same stimulus and checks
// both every cycle against a queue-based model of the pixel sink's rules.
module tb_fb_pixel_sink;
  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [8:0] x_s;
  logic [7:0] y_s;
  logic [2:0] c_s;
  logic       we_s, grant_s, clr_req_s;
  logic [2:0] clr_col_s;

  fb_pixel_sink_if pix0 ();
  fb_pixel_sink_if pix1 ();

  assign pix0.x_stream = x_s;  assign pix1.x_stream = x_s;
  assign pix0.y_stream = y_s;  assign pix1.y_stream = y_s;
  assign pix0.color_stream = c_s;  assign pix1.color_stream = c_s;
  assign pix0.writeEn = we_s;  assign pix1.writeEn = we_s;

  logic        rdy_w  [2];
  logic        done_w [2];
  logic        busy_w [2];
  logic        mwe_w  [2];
  logic [16:0] addr_w [2];
  logic [2:0]  data_w [2];
  logic [15:0] drop_w [2];

  assign rdy_w[0] = pix0.ready;
  assign rdy_w[1] = pix1.ready;

  fb_pixel_sink #(.SCREEN_W(320), .SCREEN_H(240), .FIFO_DEPTH(8), .ADDR_W(17)) u_full (
    .clk(clk), .resetn(resetn), .pix(pix0),
    .clear_req(clr_req_s), .clear_color(clr_col_s), .clear_done(done_w[0]), .busy(busy_w[0]),
    .mem_grant(grant_s), .mem_we(mwe_w[0]), .mem_addr(addr_w[0]), .mem_data(data_w[0]),
    .drop_count(drop_w[0]));

  fb_pixel_sink #(.SCREEN_W(8), .SCREEN_H(4), .FIFO_DEPTH(8), .ADDR_W(17)) u_small (
    .clk(clk), .resetn(resetn), .pix(pix1),
    .clear_req(clr_req_s), .clear_color(clr_col_s), .clear_done(done_w[1]), .busy(busy_w[1]),
    .mem_grant(grant_s), .mem_we(mwe_w[1]), .mem_addr(addr_w[1]), .mem_data(data_w[1]),
    .drop_count(drop_w[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending pixels are a plain queue; a clear is an index sweeping 0..W*H-1.
  typedef struct { int addr; int color; } px_t;
  px_t mq0[$];
  px_t mq1[$];
  int  scr_w [2] = '{320, 8};
  int  scr_h [2] = '{240, 4};
  bit  m_clearing [2], m_pending [2], m_done [2];
  int  m_clr_idx [2], m_clr_col [2], m_drops [2], m_last_addr [2], m_last_data [2];
  int  done_cnt [2];

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction
  function automatic px_t qhead(input int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction
  function automatic void qpush(input int k, input px_t p);
    if (k == 0) mq0.push_back(p); else mq1.push_back(p);
  endfunction
  function automatic void qpop(input int k);
    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endfunction
  function automatic void qclear(input int k);
    if (k == 0) mq0.delete(); else mq1.delete();
  endfunction

  task automatic model_step(input int k);
    int  n, sz;
    bit  rdy, we, inb;
    px_t p;
    n  = scr_w[k] * scr_h[k];
    sz = qsize(k);
    if (!resetn) begin
      qclear(k);
      m_clearing[k] = 0; m_pending[k] = 0; m_done[k] = 0;
      m_clr_idx[k] = 0; m_clr_col[k] = 0; m_drops[k] = 0;
      m_last_addr[k] = 0; m_last_data[k] = 0;
      return;
    end
    rdy = !m_clearing[k] && !m_pending[k] && (sz < 8);
    we  = m_clearing[k] ? grant_s : (grant_s && sz > 0);
    if (we) begin
      if (m_clearing[k]) begin
        m_last_addr[k] = m_clr_idx[k];
        m_last_data[k] = m_clr_col[k];
      end else begin
        p = qhead(k);
        m_last_addr[k] = p.addr;
        m_last_data[k] = p.color;
      end
    end
    check_val($sformatf("ready%0d", k), 32'(rdy_w[k]), 32'(rdy));
    check_val($sformatf("mem_we%0d", k), 32'(mwe_w[k]), 32'(we));
    check_val($sformatf("mem_addr%0d", k), 32'(addr_w[k]), m_last_addr[k]);
    check_val($sformatf("mem_data%0d", k), 32'(data_w[k]), m_last_data[k]);
    check_val($sformatf("busy%0d", k), 32'(busy_w[k]),
              32'(sz > 0 || m_pending[k] || m_clearing[k]));
    check_val($sformatf("clear_done%0d", k), 32'(done_w[k]), 32'(m_done[k]));
    check_val($sformatf("drop_count%0d", k), 32'(drop_w[k]), m_drops[k]);
    if (done_w[k] === 1'b1) done_cnt[k]++;

    m_done[k] = m_clearing[k] && we && (m_clr_idx[k] == n - 1);
    if (m_clearing[k]) begin
      if (we) begin
        m_clr_idx[k]++;
        if (m_clr_idx[k] == n) m_clearing[k] = 0;
      end
    end else begin
      if (we) qpop(k);
      if (m_pending[k] && sz == 0) begin
        m_clearing[k] = 1; m_pending[k] = 0; m_clr_idx[k] = 0;
      end else if (clr_req_s && !m_pending[k]) begin
        m_pending[k] = 1; m_clr_col[k] = int'(clr_col_s);
      end
    end
    inb = (int'(x_s) < scr_w[k]) && (int'(y_s) < scr_h[k]);
    if (we_s) begin
      if (rdy && inb) begin
        p.addr  = int'(y_s) * scr_w[k] + int'(x_s);
        p.color = int'(c_s);
        qpush(k, p);
      end else if (m_drops[k] < 65535) begin
        m_drops[k]++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input int x, input int y, input int c);
    we_s = 1'b1; x_s = 9'(x); y_s = 8'(y); c_s = 3'(c);
  endtask

  initial begin
    resetn = 1'b0; x_s = '0; y_s = '0; c_s = '0; we_s = 1'b0;
    grant_s = 1'b0; clr_req_s = 1'b0; clr_col_s = '0;
    for (int k = 0; k < 2; k++) done_cnt[k] = 0;
    repeat (2) cycle();
    resetn = 1'b1;

    // Single pixel with grant: written the following cycle
    grant_s = 1'b1;
    drive_pix(5, 2, 3); cycle();
    we_s = 1'b0; repeat (3) cycle();

    // Fill the FIFO without grant; ninth pixel is dropped, then drain in order
    grant_s = 1'b0;
    for (int i = 0; i < 9; i++) begin drive_pix(i % 8, i % 4, (i + 1) % 8); cycle(); end
    we_s = 1'b0; cycle();
    grant_s = 1'b1; repeat (10) cycle();

    // Clipping boundaries
    drive_pix(320, 0, 1); cycle();
    drive_pix(0, 240, 2); cycle();
    drive_pix(319, 239, 6); cycle();
    drive_pix(8, 0, 4); cycle();
    drive_pix(7, 3, 7); cycle();
    we_s = 1'b0; repeat (3) cycle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      grant_s = ($urandom_range(0, 3) != 0);
      we_s    = 1'($urandom_range(0, 1));
      x_s     = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 9)) : 9'($urandom_range(0, 330));
      y_s     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 250));
      c_s     = 3'($urandom_range(0, 7));
      cycle();
    end
    we_s = 1'b0; grant_s = 1'b1; repeat (12) cycle();

    // Clear with three pixels queued; pixel attempts during the clear must be refused
    grant_s = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_pix(i + 1, i, i + 2); cycle(); end
    we_s = 1'b0;
    clr_req_s = 1'b1; clr_col_s = 3'd5; cycle();
    clr_req_s = 1'b0; grant_s = 1'b1;
    for (int i = 0; i < 300 && done_cnt[1] < 1; i++) begin
      we_s = 1'($urandom_range(0, 1));
      x_s = 9'($urandom_range(0, 7)); y_s = 8'($urandom_range(0, 3)); c_s = 3'($urandom_range(0, 7));
      cycle();
    end
    we_s = 1'b0; repeat (3) cycle();
    check_val("small_clear_done_pulses", 32'(done_cnt[1]), 32'd1);

    // Clear with grant toggling every cycle
    clr_req_s = 1'b1; clr_col_s = 3'd2; cycle();
    clr_req_s = 1'b0;
    for (int i = 0; i < 400 && done_cnt[1] < 2; i++) begin grant_s = ~grant_s; cycle(); end
    repeat (3) cycle();
    check_val("small_toggle_done_pulses", 32'(done_cnt[1]), 32'd2);

    // Full-size clear still running: reset it at address 1000
    for (int i = 0; i < 5000 && m_clr_idx[0] != 1000; i++) begin grant_s = ~grant_s; cycle(); end
    check_val("full_clear_reached_1000", 32'(m_clr_idx[0]), 32'd1000);
    check_val("full_clear_addr_before_reset", 32'(u_full.clr_addr_q), 32'd1000);
    resetn = 1'b0; cycle();
    resetn = 1'b1; grant_s = 1'b1;
    repeat (5) cycle();
    check_val("full_done_pulses", 32'(done_cnt[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
